// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
// Host-side bridge that turns UART command byte streams into single 32-bit
// accesses on the peripheral bus and returns the status byte and any read
// data as UART transmit bytes.
//
// Command stream: CMD, ADDR[15:8], ADDR[7:0], then DATA[31:24..7:0] for writes.
//   CMD[7]   1 = write, 0 = read
//   CMD[6:4] must be 000, otherwise status 0x02 is returned with no bus access
//   CMD[3:0] byte lanes
// Response: status byte (0x00 ok, 0x01 bus timeout, 0x02 bad command),
//           followed by four read-data bytes (MSB first) for a successful read.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   rxData/rxValid            received byte strobe (no backpressure)
//   txData/txValid/txReady    transmit byte handshake
//   peripheralEnable, peripheralBus_*   bus initiator signals
//   bridgeActive              high whenever the bridge is not idle
//   rxOverrun                 sticky flag: a byte arrived while not accepting
module uart_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDLE_CYCLES    = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        peripheralEnable,
    output logic        peripheralBus_we,
    output logic        peripheralBus_oe,
    input  logic        peripheralBus_busy,
    output logic [15:0] peripheralBus_address,
    output logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataWrite,
    input  logic [31:0] peripheralBus_dataRead,
    output logic        bridgeActive,
    output logic        rxOverrun
);

    localparam int BUSY_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]       IDLE_LAST = 16'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ADDR_H      = 3'd1,
        S_ADDR_L      = 3'd2,
        S_DATA        = 3'd3,
        S_BUS         = 3'd4,
        S_RESP_STATUS = 3'd5,
        S_RESP_DATA   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [15:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        status_q, status_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       idle_cnt_q, idle_cnt_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic              rx_overrun_q, rx_overrun_d;

    // Output registers, loaded from the next-state view so outputs track the state exactly.
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic [15:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_bs_q, bus_bs_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              active_q, active_d;

    logic              tx_fire_s;
    logic              bus_sel_s;

    assign tx_fire_s = tx_valid_q & txReady;

    // Next-state, command capture, counters and sticky overrun flag.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        status_d     = status_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        busy_cnt_d   = busy_cnt_q;
        rx_overrun_d = rx_overrun_q;
        case (state_q)
            S_IDLE: begin
                idle_cnt_d = 16'd0;
                busy_cnt_d = {BUSY_W{1'b0}};
                byte_cnt_d = 2'd0;
                if (rxValid) begin
                    cmd_d = rxData;
                    if (rxData[6:4] != 3'b000) begin
                        status_d = 8'h02;
                        state_d  = S_RESP_STATUS;
                    end else begin
                        state_d  = S_ADDR_H;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR_H, S_ADDR_L, S_DATA: begin
                // A byte arriving on the expiry cycle is still accepted.
                if (rxValid) begin
                    idle_cnt_d = 16'd0;
                    case (state_q)
                        S_ADDR_H: begin
                            addr_d[15:8] = rxData;
                            state_d      = S_ADDR_L;
                        end
                        S_ADDR_L: begin
                            addr_d[7:0] = rxData;
                            byte_cnt_d  = 2'd0;
                            if (cmd_q[7]) begin
                                state_d = S_DATA;
                            end else begin
                                state_d = S_BUS;
                            end
                        end
                        default: begin
                            wdata_d    = {wdata_q[23:0], rxData};
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                state_d = S_BUS;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                    endcase
                end else if (idle_cnt_q == IDLE_LAST) begin
                    idle_cnt_d = 16'd0;
                    state_d    = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            S_BUS: begin
                // Completion takes priority over timeout on the same cycle.
                if (!peripheralBus_busy) begin
                    if (!cmd_q[7]) begin
                        rdata_d = peripheralBus_dataRead;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    status_d   = 8'h00;
                    busy_cnt_d = {BUSY_W{1'b0}};
                    state_d    = S_RESP_STATUS;
                end else if (busy_cnt_q == BUSY_LAST) begin
                    status_d   = 8'h01;
                    busy_cnt_d = {BUSY_W{1'b0}};
                    state_d    = S_RESP_STATUS;
                end else begin
                    busy_cnt_d = busy_cnt_q + {{(BUSY_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESP_STATUS: begin
                if (tx_fire_s) begin
                    if ((status_q == 8'h00) && !cmd_q[7]) begin
                        byte_cnt_d = 2'd0;
                        state_d    = S_RESP_DATA;
                    end else begin
                        state_d    = S_IDLE;
                    end
                end else begin
                    state_d = S_RESP_STATUS;
                end
            end
            S_RESP_DATA: begin
                if (tx_fire_s) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RESP_DATA;
                    end
                end else begin
                    state_d = S_RESP_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rxValid && ((state_q == S_BUS) || (state_q == S_RESP_STATUS) ||
                        (state_q == S_RESP_DATA))) begin
            rx_overrun_d = 1'b1;
        end else begin
            rx_overrun_d = rx_overrun_q;
        end
    end

    // Output values for the coming cycle; bus signals are forced to 0 outside BUS.
    always_comb begin
        bus_sel_s   = (state_d == S_BUS);
        en_d        = bus_sel_s;
        we_d        = bus_sel_s & cmd_d[7];
        oe_d        = bus_sel_s & ~cmd_d[7];
        bus_addr_d  = bus_sel_s ? addr_d : 16'h0000;
        bus_bs_d    = bus_sel_s ? cmd_d[3:0] : 4'h0;
        bus_wdata_d = bus_sel_s ? wdata_d : 32'h0000_0000;
        tx_valid_d  = (state_d == S_RESP_STATUS) || (state_d == S_RESP_DATA);
        active_d    = (state_d != S_IDLE);
        tx_data_d   = 8'h00;
        case (state_d)
            S_RESP_STATUS: tx_data_d = status_d;
            S_RESP_DATA: begin
                case (byte_cnt_d)
                    2'd0:    tx_data_d = rdata_d[31:24];
                    2'd1:    tx_data_d = rdata_d[23:16];
                    2'd2:    tx_data_d = rdata_d[15:8];
                    default: tx_data_d = rdata_d[7:0];
                endcase
            end
            default: tx_data_d = 8'h00;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= 8'h00;
            addr_q       <= 16'h0000;
            wdata_q      <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            status_q     <= 8'h00;
            byte_cnt_q   <= 2'd0;
            idle_cnt_q   <= 16'd0;
            busy_cnt_q   <= {BUSY_W{1'b0}};
            rx_overrun_q <= 1'b0;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            bus_addr_q   <= 16'h0000;
            bus_bs_q     <= 4'h0;
            bus_wdata_q  <= 32'h0000_0000;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            status_q     <= status_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
            rx_overrun_q <= rx_overrun_d;
            en_q         <= en_d;
            we_q         <= we_d;
            oe_q         <= oe_d;
            bus_addr_q   <= bus_addr_d;
            bus_bs_q     <= bus_bs_d;
            bus_wdata_q  <= bus_wdata_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            active_q     <= active_d;
        end
    end

    assign peripheralEnable         = en_q;
    assign peripheralBus_we         = we_q;
    assign peripheralBus_oe         = oe_q;
    assign peripheralBus_address    = bus_addr_q;
    assign peripheralBus_byteSelect = bus_bs_q;
    assign peripheralBus_dataWrite  = bus_wdata_q;
    assign txValid                  = tx_valid_q;
    assign txData                   = tx_data_q;
    assign bridgeActive             = active_q;
    assign rxOverrun                = rx_overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge (TIMEOUT_CYCLES=8, IDLE_CYCLES=16).
// Inputs change 1 time unit after the rising edge; outputs are observed on the
// falling edge by a monitor that logs bus cycles and accepted tx bytes.
module tb_uart_bus_bridge;

    logic        clk;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic        peripheralEnable;
    logic        peripheralBus_we;
    logic        peripheralBus_oe;
    logic        peripheralBus_busy;
    logic [15:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead;
    logic        bridgeActive;
    logic        rxOverrun;

    int checks   = 0;
    int failures = 0;

    int          stall_n;
    int          acc_cnt    = 0;
    int          en_total   = 0;
    int          tx_total   = 0;
    int          stable_err = 0;
    logic [7:0]  tx_log [0:63];
    logic        cap_we, cap_oe;
    logic [15:0] cap_addr;
    logic [3:0]  cap_bs;
    logic [31:0] cap_dw;
    int          en_base, tx_base;

    uart_bus_bridge #(
        .TIMEOUT_CYCLES(8),
        .IDLE_CYCLES   (16)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .rxData                  (rxData),
        .rxValid                 (rxValid),
        .txData                  (txData),
        .txValid                 (txValid),
        .txReady                 (txReady),
        .peripheralEnable        (peripheralEnable),
        .peripheralBus_we        (peripheralBus_we),
        .peripheralBus_oe        (peripheralBus_oe),
        .peripheralBus_busy      (peripheralBus_busy),
        .peripheralBus_address   (peripheralBus_address),
        .peripheralBus_byteSelect(peripheralBus_byteSelect),
        .peripheralBus_dataWrite (peripheralBus_dataWrite),
        .peripheralBus_dataRead  (peripheralBus_dataRead),
        .bridgeActive            (bridgeActive),
        .rxOverrun               (rxOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: busy for the first stall_n cycles of each access.
    assign peripheralBus_busy = peripheralEnable && (acc_cnt <= stall_n);

    // Monitor: count enable cycles, capture first-cycle bus values, log tx bytes.
    always @(negedge clk) begin
        if (peripheralEnable) begin
            acc_cnt  <= acc_cnt + 1;
            en_total <= en_total + 1;
            if (acc_cnt == 0) begin
                cap_we   <= peripheralBus_we;
                cap_oe   <= peripheralBus_oe;
                cap_addr <= peripheralBus_address;
                cap_bs   <= peripheralBus_byteSelect;
                cap_dw   <= peripheralBus_dataWrite;
            end else if ({peripheralBus_we, peripheralBus_oe, peripheralBus_address,
                          peripheralBus_byteSelect, peripheralBus_dataWrite} !==
                         {cap_we, cap_oe, cap_addr, cap_bs, cap_dw}) begin
                stable_err <= stable_err + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
        if (txValid && txReady) begin
            tx_log[tx_total[5:0]] <= txData;
            tx_total <= tx_total + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        step();
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic mark();
        en_base = en_total;
        tx_base = tx_total;
    endtask

    // Wait until the bridge returns to IDLE, then realign to just after an edge.
    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (bridgeActive && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, {31'd0, bridgeActive}, 32'd0);
        step();
    endtask

    task automatic check_tx(input string tag, input int n, input logic [39:0] exp_bytes);
        logic [39:0] eb;
        eb = exp_bytes;
        check_eq({tag, "_txcnt"}, tx_total - tx_base, n);
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_txbyte"}, {24'd0, tx_log[(tx_base + i) % 64]},
                     {24'd0, eb[39 - 8*i -: 8]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        rxData  = 8'h00;
        rxValid = 1'b0;
        txReady = 1'b1;
        stall_n = 0;
        peripheralBus_dataRead = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_en",     {31'd0, peripheralEnable}, 32'd0);
        check_eq("rst_txv",    {31'd0, txValid}, 32'd0);
        check_eq("rst_active", {31'd0, bridgeActive}, 32'd0);
        check_eq("rst_ovr",    {31'd0, rxOverrun}, 32'd0);
        check_eq("rst_addr",   {16'd0, peripheralBus_address}, 32'd0);
        rst = 1'b0;
        step();

        // Write, no stall.
        mark();
        stall_n = 0;
        send_byte(8'h8F); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("wr", 50);
        check_eq("wr_encyc", en_total - en_base, 1);
        check_eq("wr_we",    {31'd0, cap_we}, 32'd1);
        check_eq("wr_oe",    {31'd0, cap_oe}, 32'd0);
        check_eq("wr_addr",  {16'd0, cap_addr}, 32'h0010);
        check_eq("wr_bs",    {28'd0, cap_bs}, 32'hF);
        check_eq("wr_data",  cap_dw, 32'hDEADBEEF);
        check_tx("wr", 1, 40'h00_00000000);
        check_eq("wr_addr_clr", {16'd0, peripheralBus_address}, 32'd0);
        check_eq("wr_dw_clr",   peripheralBus_dataWrite, 32'd0);

        // Read with a 5-cycle stall.
        mark();
        stall_n = 5;
        peripheralBus_dataRead = 32'hCAFEF00D;
        send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
        wait_idle("rd", 80);
        check_eq("rd_encyc", en_total - en_base, 6);
        check_eq("rd_oe",    {31'd0, cap_oe}, 32'd1);
        check_eq("rd_we",    {31'd0, cap_we}, 32'd0);
        check_eq("rd_addr",  {16'd0, cap_addr}, 32'h1234);
        check_eq("rd_bs",    {28'd0, cap_bs}, 32'h3);
        check_tx("rd", 5, 40'h00_CAFEF00D);
        check_eq("rd_txv_low", {31'd0, txValid}, 32'd0);

        // Bus timeout after 8 cycles.
        mark();
        stall_n = 1000;
        send_byte(8'h0F); send_byte(8'h00); send_byte(8'h44);
        wait_idle("to", 80);
        check_eq("to_encyc", en_total - en_base, 8);
        check_tx("to", 1, 40'h01_00000000);

        // Inter-byte timeout: partial command discarded after 16 silent cycles.
        mark();
        stall_n = 0;
        send_byte(8'h8F); send_byte(8'h00);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_eq("ib_still_active", {31'd0, bridgeActive}, 32'd1);
        @(negedge clk);
        check_eq("ib_dropped", {31'd0, bridgeActive}, 32'd0);
        step();
        check_eq("ib_encyc", en_total - en_base, 0);
        check_eq("ib_txcnt", tx_total - tx_base, 0);
        mark();
        peripheralBus_dataRead = 32'h11223344;
        send_byte(8'h0F); send_byte(8'h00); send_byte(8'h20);
        wait_idle("ib_rd", 80);
        check_eq("ib_rd_addr", {16'd0, cap_addr}, 32'h0020);
        check_eq("ib_rd_bs",   {28'd0, cap_bs}, 32'hF);
        check_tx("ib_rd", 5, 40'h00_11223344);

        // Bad command plus overrun while the status byte is held.
        mark();
        txReady = 1'b0;
        send_byte(8'h40);
        send_byte(8'h55);
        step();
        @(negedge clk);
        check_eq("bad_txv",  {31'd0, txValid}, 32'd1);
        check_eq("bad_txd",  {24'd0, txData}, 32'h02);
        check_eq("bad_ovr",  {31'd0, rxOverrun}, 32'd1);
        step();
        txReady = 1'b1;
        wait_idle("bad", 20);
        check_eq("bad_encyc", en_total - en_base, 0);
        check_tx("bad", 1, 40'h02_00000000);
        check_eq("ovr_sticky", {31'd0, rxOverrun}, 32'd1);

        // Async reset in the middle of a stalled bus access.
        mark();
        stall_n = 1000;
        send_byte(8'h0F); send_byte(8'h00); send_byte(8'h08);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rbus_en",     {31'd0, peripheralEnable}, 32'd0);
        check_eq("rbus_oe",     {31'd0, peripheralBus_oe}, 32'd0);
        check_eq("rbus_active", {31'd0, bridgeActive}, 32'd0);
        check_eq("rbus_ovr",    {31'd0, rxOverrun}, 32'd0);
        step();
        rst = 1'b0;
        repeat (20) step();
        check_eq("rbus_txcnt", tx_total - tx_base, 0);

        // Async reset while read data is being returned.
        mark();
        stall_n = 0;
        peripheralBus_dataRead = 32'hAABBCCDD;
        send_byte(8'h0F); send_byte(8'h00); send_byte(8'h0C);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if ((tx_total - tx_base) >= 2) break;
        end
        check_eq("rdat_reached", tx_total - tx_base, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rdat_txv",    {31'd0, txValid}, 32'd0);
        check_eq("rdat_txd",    {24'd0, txData}, 32'd0);
        check_eq("rdat_active", {31'd0, bridgeActive}, 32'd0);
        step();
        rst = 1'b0;
        repeat (20) step();
        check_eq("rdat_txcnt", tx_total - tx_base, 2);
        check_eq("bus_stable", stable_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
